rf_tile: RTL and testbench
==========================

RF_TILE -- requirements
Module: rf_tile

Interface
REQ-001 SHALL have parameters: N, default 8, array dimension (rows = columns).
REQ-002 SHALL have parameter DATA_W, default 16, width of operands and accumulators.
REQ-003 SHALL have parameter DEPTH, default 32, number of register-file entries.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port RF_EN, input, 1 bit: enables a register-file write or a streaming step.
REQ-008 Port WRITE, input, 1 bit: selects the mode; 1 = load/clear, 0 = stream/compute.
REQ-009 Port IDX, input, 5 bits: register-file entry written when WRITE=1.
REQ-010 Port DIN, input, 2*N x DATA_W: lanes 0..N-1 carry A column k (rows 0..N-1); lanes N..2N-1 carry B row k (columns 0..N-1).
REQ-011 Port Y, output, N x N x DATA_W: accumulator of PE(i,j).
REQ-012 Port X_EDGE, output, N x DATA_W: X value leaving the right edge of each row.
REQ-013 Port W_EDGE, output, N x DATA_W: W value leaving the bottom edge of each column.
REQ-014 Port DONE, output, 1 bit: high once every Y holds its final value.

Function
REQ-015 When RF_EN=1 and WRITE=1, the block SHALL store all 2N DIN lanes into entry IDX on the next edge.
REQ-016 While WRITE=1, the block SHALL clear the following to 0: all accumulators, all PE pipeline registers, all skew registers, the stream counter S and DONE.
REQ-017 A step SHALL occur only on a cycle with RF_EN=1 and WRITE=0; on all other cycles with WRITE=0, all state SHALL hold.
REQ-018 On a step t (t = S), the row-r edge input SHALL be A lane r of entry t-r, provided 0 <= t-r <= DEPTH-1; otherwise it SHALL be 0.
REQ-019 On a step t, the column-c edge input SHALL be B lane c of entry t-c, under the same range rule; otherwise it SHALL be 0.
REQ-020 The edge skew SHALL be realised with registers; each edge input SHALL be registered once before entering the array.
REQ-021 On each step, PE(i,j) SHALL compute acc <= acc + x*w, truncated modulo 2^DATA_W (unsigned).
REQ-022 On each step, PE(i,j) SHALL pass x to PE(i,j+1) and w to PE(i+1,j), each delayed by one register.
REQ-023 X_EDGE and W_EDGE SHALL be the registered x/w outputs of column N-1 and row N-1 respectively.
REQ-024 Steps SHALL increment S, and S SHALL saturate at DEPTH+2N-1 (47 for the defaults).
REQ-025 DONE SHALL equal (S == DEPTH+2N-1).
REQ-026 Once DONE=1, Y[i][j] SHALL equal sum over k of A[i][k]*B[k][j] mod 2^DATA_W, and further steps SHALL add only zeros.
REQ-027 A write with WRITE=1 during streaming SHALL abort the computation (REQ-016 clear); entry contents SHALL be retained.

Reset
REQ-028 RST SHALL asynchronously clear to 0 all register-file entries, accumulators, pipeline registers, skew registers, S and DONE.
REQ-029 Consequently, every output SHALL read 0 while reset is asserted and immediately after it.
REQ-030 Assertion of RST mid-stream SHALL discard all progress.

Structure
REQ-031 N, DATA_W and DEPTH defaults and the derived DONE count SHALL live in the shared package rf_tile_pkg.
REQ-032 A single sub-module sa_pe SHALL hold one PE (x register, w register, accumulator), instantiated N x N.
REQ-033 The register file, skew logic and counter SHALL reside in rf_tile itself.

Verification
REQ-034 Reset; write entries 0..7 with all lanes = 1; stream 47 steps -> DONE=1 and every Y = 8.
REQ-035 Write A = identity and B[k][j] = 8k+j over entries 0..7; stream -> Y[i][j] = 8i+j.
REQ-036 Write entry 0 with all lanes 0x0100; stream -> every Y = 0x0000 (wrap-around).
REQ-037 Run the REQ-034 case with RF_EN deasserted for 5 random cycles mid-stream -> identical Y; DONE is delayed by 5 cycles.
REQ-038 Pulse RST at step 20 of the REQ-034 case, rewrite, restream -> Y = 8 (not 8 plus a partial sum).
REQ-039 Pulse WRITE=1 with RF_EN=0 at step 20, then restream -> all Y = 8, and the entries are intact.

Source files
------------

// File: rtl/rf_tile_pkg.sv
// rtl/rf_tile_pkg.sv - shared sizing defaults and derived stream length for rf_tile
package rf_tile_pkg;

  localparam int N_DEF      = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 32;
  localparam int IDX_W      = 5;

  // Last useful MAC lands on step DEPTH+2N-2; the counter then parks one past it.
  function automatic int done_count(input int depth, input int n);
    return depth + 2 * n - 1;
  endfunction

  localparam int DONE_CNT_DEF = done_count(DEPTH_DEF, N_DEF);

endpackage

// File: rtl/rf_tile_sa_pe.sv
// rtl/rf_tile_sa_pe.sv - one systolic processing element: x/w forwarding registers and MAC accumulator
module sa_pe #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EN,
  input  logic [DATA_W-1:0] X_IN,
  input  logic [DATA_W-1:0] W_IN,
  output logic [DATA_W-1:0] X_OUT,
  output logic [DATA_W-1:0] W_OUT,
  output logic [DATA_W-1:0] ACC
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      X_OUT <= '0;
      W_OUT <= '0;
      ACC   <= '0;
    end else if (CLR) begin
      X_OUT <= '0;
      W_OUT <= '0;
      ACC   <= '0;
    end else if (EN) begin
      X_OUT <= X_IN;
      W_OUT <= W_IN;
      // Product and sum both wrap at DATA_W bits.
      ACC   <= ACC + X_IN * W_IN;
    end
  end

endmodule

// File: rtl/rf_tile.sv
// rtl/rf_tile.sv - register file feeding an N x N output-stationary systolic multiply array
module rf_tile
  import rf_tile_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               RF_EN,
  input  logic                               WRITE,
  input  logic [IDX_W-1:0]                   IDX,
  input  logic [2*N-1:0][DATA_W-1:0]         DIN,
  output logic [N-1:0][N-1:0][DATA_W-1:0]    Y,
  output logic [N-1:0][DATA_W-1:0]           X_EDGE,
  output logic [N-1:0][DATA_W-1:0]           W_EDGE,
  output logic                               DONE
);

  localparam int S_MAX = done_count(DEPTH, N);
  localparam int S_W   = $clog2(S_MAX + 1);
  localparam int A_W   = $clog2(DEPTH);

  logic [2*N-1:0][DATA_W-1:0] rf [DEPTH];
  logic [S_W-1:0]             s_cnt;
  logic                       step;
  logic [N-1:0][DATA_W-1:0]   a_edge;
  logic [N-1:0][DATA_W-1:0]   b_edge;
  logic [N-1:0][DATA_W-1:0]   x_skew;
  logic [N-1:0][DATA_W-1:0]   w_skew;
  logic [DATA_W-1:0]          x_link [N][N+1];
  logic [DATA_W-1:0]          w_link [N+1][N];

  assign step = RF_EN && !WRITE;
  assign DONE = (s_cnt == S_W'(S_MAX));

  // Entries survive WRITE-driven clears; only RST wipes them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int e = 0; e < DEPTH; e++) rf[e] <= '0;
    end else if (RF_EN && WRITE && int'(IDX) < DEPTH) begin
      rf[A_W'(IDX)] <= DIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_cnt <= '0;
    end else if (WRITE) begin
      s_cnt <= '0;
    end else if (step && s_cnt != S_W'(S_MAX)) begin
      s_cnt <= s_cnt + 1'b1;
    end
  end

  // Row/column r reads entry S-r, giving the diagonal skew without shift chains.
  always_comb begin
    a_edge = '0;
    b_edge = '0;
    for (int r = 0; r < N; r++) begin
      if (int'(s_cnt) >= r && int'(s_cnt) - r < DEPTH) begin
        a_edge[r] = rf[A_W'(int'(s_cnt) - r)][r];
        b_edge[r] = rf[A_W'(int'(s_cnt) - r)][N + r];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_skew <= '0;
      w_skew <= '0;
    end else if (WRITE) begin
      x_skew <= '0;
      w_skew <= '0;
    end else if (step) begin
      x_skew <= a_edge;
      w_skew <= b_edge;
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < N; gi++) begin : g_row
    assign x_link[gi][0] = x_skew[gi];
    assign X_EDGE[gi]    = x_link[gi][N];
    assign w_link[0][gi] = w_skew[gi];
    assign W_EDGE[gi]    = w_link[N][gi];
    for (gj = 0; gj < N; gj++) begin : g_col
      sa_pe #(.DATA_W(DATA_W)) u_pe (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (WRITE),
        .EN    (step),
        .X_IN  (x_link[gi][gj]),
        .W_IN  (w_link[gi][gj]),
        .X_OUT (x_link[gi][gj+1]),
        .W_OUT (w_link[gi+1][gj]),
        .ACC   (Y[gi][gj])
      );
    end
  end

endmodule

// File: tb/tb_rf_tile.sv
// tb/tb_rf_tile.sv - scoreboard bench for rf_tile matrix streaming
module tb_rf_tile;

  localparam int N      = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int S_DONE = DEPTH + 2 * N - 1;

  logic                            CLK;
  logic                            RST;
  logic                            RF_EN;
  logic                            WRITE;
  logic [4:0]                      IDX;
  logic [2*N-1:0][DATA_W-1:0]      DIN;
  logic [N-1:0][N-1:0][DATA_W-1:0] Y;
  logic [N-1:0][DATA_W-1:0]        X_EDGE;
  logic [N-1:0][DATA_W-1:0]        W_EDGE;
  logic                            DONE;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mrf [DEPTH][2*N];
  logic [DATA_W-1:0] sb [$];

  rf_tile #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .RF_EN  (RF_EN),
    .WRITE  (WRITE),
    .IDX    (IDX),
    .DIN    (DIN),
    .Y      (Y),
    .X_EDGE (X_EDGE),
    .W_EDGE (W_EDGE),
    .DONE   (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_y%0d%0d", tag, i, j), 64'(Y[i][j]), 64'd0);
    for (int r = 0; r < N; r++) begin
      chk($sformatf("%s_xe%0d", tag, r), 64'(X_EDGE[r]), 64'd0);
      chk($sformatf("%s_we%0d", tag, r), 64'(W_EDGE[r]), 64'd0);
    end
    chk({tag, "_done"}, 64'(DONE), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    RF_EN = 1'b0;
    WRITE = 1'b0;
    #2 RST = 1'b1;
    #1 chk_all_zero({tag, "_async"});
    @(posedge CLK);
    #1 RST = 1'b0;
    #1 chk_all_zero({tag, "_after"});
    for (int e = 0; e < DEPTH; e++)
      for (int l = 0; l < 2 * N; l++) mrf[e][l] = '0;
  endtask

  task automatic write_entry(input int idx, input logic [2*N-1:0][DATA_W-1:0] d);
    @(posedge CLK);
    #1;
    RF_EN = 1'b1;
    WRITE = 1'b1;
    IDX   = 5'(idx);
    DIN   = d;
    @(posedge CLK);
    #1;
    RF_EN = 1'b0;
    WRITE = 1'b0;
    for (int l = 0; l < 2 * N; l++) mrf[idx][l] = d[l];
  endtask

  task automatic write_ones();
    logic [2*N-1:0][DATA_W-1:0] d;
    for (int l = 0; l < 2 * N; l++) d[l] = 16'd1;
    for (int k = 0; k < 8; k++) write_entry(k, d);
  endtask

  // Y[i][j] = sum_k A[i][k]*B[k][j], A column k in lanes 0..N-1, B row k in lanes N..2N-1.
  task automatic push_expected();
    logic [DATA_W-1:0] acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < DEPTH; k++) acc = acc + mrf[k][i] * mrf[k][N + j];
        sb.push_back(acc);
      end
  endtask

  task automatic compare_y(input string tag);
    logic [DATA_W-1:0] e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          chk($sformatf("%s_y%0d%0d", tag, i, j), 64'(Y[i][j]), 64'(e));
        end
      end
  endtask

  task automatic run_steps(input int n);
    RF_EN = 1'b1;
    WRITE = 1'b0;
    repeat (n) @(posedge CLK);
    #1 RF_EN = 1'b0;
  endtask

  task automatic stream_check(input string tag, input int n_stall);
    bit [199:0] stall_map;
    int cyc;
    int placed;
    stall_map = '0;
    placed = 0;
    while (placed < n_stall) begin
      int p;
      p = int'($urandom_range(5, 40));
      if (!stall_map[p]) begin
        stall_map[p] = 1'b1;
        placed++;
      end
    end
    push_expected();
    cyc = 0;
    WRITE = 1'b0;
    while (!DONE && cyc < 200) begin
      RF_EN = !stall_map[cyc];
      @(posedge CLK);
      #1 cyc++;
    end
    RF_EN = 1'b0;
    chk({tag, "_done"}, 64'(DONE), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(S_DONE + n_stall));
    compare_y(tag);
    push_expected();
    run_steps(3);
    chk({tag, "_post_done"}, 64'(DONE), 64'd1);
    compare_y({tag, "_post"});
  endtask

  initial begin
    logic [2*N-1:0][DATA_W-1:0] d;
    RST   = 1'b0;
    RF_EN = 1'b0;
    WRITE = 1'b0;
    IDX   = '0;
    DIN   = '0;

    do_reset("rst0");
    write_ones();
    stream_check("ones", 0);

    do_reset("rst1");
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) d[i] = (i == k) ? 16'd1 : 16'd0;
      for (int j = 0; j < N; j++) d[N + j] = 16'(8 * k + j);
      write_entry(k, d);
    end
    stream_check("ident", 0);

    do_reset("rst2");
    for (int l = 0; l < 2 * N; l++) d[l] = 16'h0100;
    write_entry(0, d);
    stream_check("wrap", 0);

    do_reset("rst3");
    write_ones();
    stream_check("stall", 5);

    do_reset("rst4");
    write_ones();
    run_steps(20);
    do_reset("midrst");
    write_ones();
    stream_check("after_rst", 0);

    do_reset("rst5");
    write_ones();
    run_steps(20);
    RF_EN = 1'b0;
    WRITE = 1'b1;
    @(posedge CLK);
    #1 WRITE = 1'b0;
    chk("abort_y00", 64'(Y[0][0]), 64'd0);
    chk("abort_y77", 64'(Y[N-1][N-1]), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    stream_check("after_abort", 0);

    do_reset("rst6");
    for (int k = 0; k < DEPTH; k++) begin
      for (int l = 0; l < 2 * N; l++) d[l] = 16'($urandom);
      write_entry(k, d);
    end
    stream_check("random", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
